// File: rtl/spi_flash_reader.sv
// Serial NOR flash reader: issues READ (0x03) and JEDEC ID (0x9F) transactions over
// SPI mode 0 and streams the returned bytes out one strobe at a time.

module spi_flash_byte #(
  parameter int SCLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] din,
  input  logic       finish,
  input  logic       miso,
  output logic       ready,
  output logic       done,
  output logic [7:0] dout,
  output logic       sclk,
  output logic       mosi,
  output logic       cs
);
  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = $clog2(SCLK_DIV);

  logic [CW-1:0] div_cnt_r;
  logic [CW-1:0] guard_r;
  logic [2:0]    bit_cnt_r;
  logic          busy_r;
  logic          cs_r;
  logic          sclk_r;
  logic          mosi_r;
  logic [7:0]    tx_r;
  logic [7:0]    rx_r;
  logic          sclk_done_s;
  logic          rise_s;

  assign sclk_done_s = busy_r && (div_cnt_r == CW'(SCLK_DIV - 1));
  assign rise_s      = busy_r && (div_cnt_r == CW'(HALF - 1));
  // From idle, cs must have been high for the full guard time before the next frame.
  assign ready       = !busy_r && (!cs_r || (guard_r == {CW{1'b0}}));
  assign done        = sclk_done_s && (bit_cnt_r == 3'd7);
  assign dout        = rx_r;
  assign sclk        = sclk_r;
  assign mosi        = mosi_r;
  assign cs          = cs_r;

  // Byte shifter: clock divider, bit counter, chip select and guard timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= {CW{1'b0}};
      guard_r   <= {CW{1'b0}};
      bit_cnt_r <= 3'd0;
      busy_r    <= 1'b0;
      cs_r      <= 1'b1;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      tx_r      <= 8'h00;
      rx_r      <= 8'h00;
    end else begin
      if (guard_r != {CW{1'b0}}) begin
        guard_r <= guard_r - CW'(1);
      end
      if (finish) begin
        cs_r    <= 1'b1;
        busy_r  <= 1'b0;
        sclk_r  <= 1'b0;
        guard_r <= CW'(SCLK_DIV - 1);
      end else if (busy_r) begin
        if (rise_s) begin
          rx_r <= {rx_r[6:0], miso};
        end
        if (sclk_done_s) begin
          div_cnt_r <= {CW{1'b0}};
          sclk_r    <= 1'b0;
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            busy_r <= 1'b0;
          end else begin
            mosi_r <= tx_r[6];
            tx_r   <= {tx_r[6:0], 1'b0};
          end
        end else begin
          div_cnt_r <= div_cnt_r + CW'(1);
          sclk_r    <= (div_cnt_r >= CW'(HALF - 1));
        end
      end else if (req && ready) begin
        busy_r    <= 1'b1;
        cs_r      <= 1'b0;
        div_cnt_r <= {CW{1'b0}};
        bit_cnt_r <= 3'd0;
        sclk_r    <= 1'b0;
        tx_r      <= din;
        mosi_r    <= din[7];
      end
    end
  end
endmodule

module spi_flash_reader #(
  parameter int          SCLK_DIV   = 4,
  parameter int          RD_LEN     = 16,
  parameter logic [23:0] START_ADDR = 24'h000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rden,
  input  logic       rdid,
  output logic [7:0] rddata,
  output logic       rddata_vld,
  output logic       rddone,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        id_r, id_s;
  logic        issued_r, issued_s;
  logic        end_wait_r, end_wait_s;
  logic [8:0]  cnt_r, cnt_s;
  logic [23:0] addr_r, addr_s;
  logic [7:0]  rddata_r, rddata_s;
  logic        vld_r, vld_s;
  logic        rddone_r, rddone_s;
  logic        req_s;
  logic [7:0]  din_s;
  logic        finish_s;
  logic [8:0]  data_last_s;
  logic        ready_s;
  logic        done_s;
  logic [7:0]  dout_s;

  spi_flash_byte #(.SCLK_DIV(SCLK_DIV)) u_byte (
    .clk    (clk),
    .rst    (rst),
    .req    (req_s),
    .din    (din_s),
    .finish (finish_s),
    .miso   (spi_miso),
    .ready  (ready_s),
    .done   (done_s),
    .dout   (dout_s),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi),
    .cs     (spi_cs)
  );

  assign data_last_s = id_r ? 9'd2 : 9'(RD_LEN - 1);
  assign rddata      = rddata_r;
  assign rddata_vld  = vld_r;
  assign rddone      = rddone_r;

  // Sequencer state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      id_r       <= 1'b0;
      issued_r   <= 1'b0;
      end_wait_r <= 1'b0;
      cnt_r      <= 9'd0;
      addr_r     <= START_ADDR;
      rddata_r   <= 8'h00;
      vld_r      <= 1'b0;
      rddone_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      id_r       <= id_s;
      issued_r   <= issued_s;
      end_wait_r <= end_wait_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      rddata_r   <= rddata_s;
      vld_r      <= vld_s;
      rddone_r   <= rddone_s;
    end
  end

  // Next-state logic: one byte request in flight at a time, advanced on byte done.
  always_comb begin
    state_s    = state_r;
    id_s       = id_r;
    issued_s   = issued_r;
    end_wait_s = end_wait_r;
    cnt_s      = cnt_r;
    addr_s     = addr_r;
    rddata_s   = rddata_r;
    vld_s      = 1'b0;
    rddone_s   = 1'b0;
    req_s      = 1'b0;
    din_s      = 8'h00;
    finish_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        issued_s = 1'b0;
        cnt_s    = 9'd0;
        if (rden) begin
          state_s = S_CMD;
          id_s    = 1'b0;
        end else if (rdid) begin
          state_s = S_CMD;
          id_s    = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CMD: begin
        req_s = !issued_r;
        din_s = id_r ? 8'h9F : 8'h03;
        if (done_s) begin
          issued_s = 1'b0;
          cnt_s    = 9'd0;
          state_s  = id_r ? S_DATA : S_ADDR;
        end else if (req_s && ready_s) begin
          issued_s = 1'b1;
        end else begin
          issued_s = issued_r;
        end
      end
      S_ADDR: begin
        req_s = !issued_r;
        case (cnt_r[1:0])
          2'd0:    din_s = addr_r[23:16];
          2'd1:    din_s = addr_r[15:8];
          default: din_s = addr_r[7:0];
        endcase
        if (done_s) begin
          issued_s = 1'b0;
          if (cnt_r == 9'd2) begin
            cnt_s   = 9'd0;
            state_s = S_DATA;
          end else begin
            cnt_s = cnt_r + 9'd1;
          end
        end else if (req_s && ready_s) begin
          issued_s = 1'b1;
        end else begin
          issued_s = issued_r;
        end
      end
      S_DATA: begin
        req_s = !issued_r;
        din_s = 8'h00;
        if (done_s) begin
          issued_s = 1'b0;
          vld_s    = 1'b1;
          rddata_s = dout_s;
          if (cnt_r == data_last_s) begin
            cnt_s   = 9'd0;
            state_s = S_END;
          end else begin
            cnt_s = cnt_r + 9'd1;
          end
        end else if (req_s && ready_s) begin
          issued_s = 1'b1;
        end else begin
          issued_s = issued_r;
        end
      end
      S_END: begin
        // First cycle raises cs; rddone follows once cs is already high.
        finish_s = !end_wait_r;
        if (!end_wait_r) begin
          end_wait_s = 1'b1;
        end else begin
          end_wait_s = 1'b0;
          state_s    = S_IDLE;
          rddone_s   = 1'b1;
          if (!id_r) begin
            addr_s = addr_r + 24'(RD_LEN);
          end else begin
            addr_s = addr_r;
          end
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: a small flash model on the SPI pins records
// mosi bytes, replays miso bytes from a table and counts strobes.

module tb_spi_flash_reader;
  localparam int SCLK_DIV = 4;
  localparam int RD_LEN   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rden = 1'b0;
  logic       rdid = 1'b0;
  logic [7:0] rddata;
  logic       rddata_vld;
  logic       rddone;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
  logic       spi_cs;

  always #5 clk = ~clk;

  spi_flash_reader #(.SCLK_DIV(SCLK_DIV), .RD_LEN(RD_LEN), .START_ADDR(24'h000000)) dut (
    .clk(clk), .rst(rst), .rden(rden), .rdid(rdid), .rddata(rddata),
    .rddata_vld(rddata_vld), .rddone(rddone), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
  );

  int checks = 0;
  int passed = 0;

  logic [7:0] mosi_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] miso_tab [0:19];
  int rises = 0, cs_low_cyc = 0, cs_falls = 0, vld_cnt = 0, done_cnt = 0;
  int hi_run = 0, min_hi = 1000000;
  int bidx = 0, mbit = 0, mbyte = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] cur_b;
  logic cs_p = 1'b1, sclk_p = 1'b0;

  // Flash model, sampled on the falling clk edge: mosi on sclk rise, miso changes after sclk fall.
  always @(negedge clk) begin
    if (cs_p && !spi_cs) begin
      if (hi_run < min_hi) min_hi = hi_run;
      cs_falls++;
      bidx = 0; mbit = 0; mbyte = 0;
    end
    if (spi_cs) hi_run++;
    else begin
      hi_run = 0;
      cs_low_cyc++;
    end
    if (!spi_cs && spi_sclk && !sclk_p) begin
      sh = {sh[6:0], spi_mosi};
      rises++;
      bidx++;
      if (bidx == 8) begin
        mosi_q.push_back(sh);
        bidx = 0;
      end
    end
    if (!spi_cs && !spi_sclk && sclk_p) begin
      mbit++;
      if (mbit == 8) begin
        mbit = 0;
        mbyte++;
      end
    end
    if (rddata_vld === 1'b1) begin
      vld_cnt++;
      rd_q.push_back(rddata);
    end
    if (rddone === 1'b1) done_cnt++;
    cur_b = miso_tab[(mbyte > 19) ? 19 : mbyte];
    spi_miso = cur_b[7 - mbit];
    cs_p = spi_cs;
    sclk_p = spi_sclk;
  end

  function automatic logic [7:0] qget(input int i);
    if (i < mosi_q.size()) return mosi_q[i];
    return 8'hxx;
  endfunction

  function automatic logic [23:0] addr_at(input int m0);
    return {qget(m0 + 1), qget(m0 + 2), qget(m0 + 3)};
  endfunction

  task automatic start(input logic a, input logic b);
    rden = a;
    rdid = b;
    @(negedge clk);
    rden = 1'b0;
    rdid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (rddone === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic run_txn(input logic a, input logic b, output bit ok);
    start(a, b);
    wait_done(ok);
  endtask

  task automatic fill_tab(input logic [7:0] v);
    for (int i = 0; i < 20; i++) miso_tab[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_cs, spi_sclk, spi_mosi, rddata_vld, rddone, rddata} !== {5'b10000, 8'h00})
      $display("FAIL reset_outputs: got cs,sclk,mosi,vld,done,data=%b required 1000000000000",
               {spi_cs, spi_sclk, spi_mosi, rddata_vld, rddone, rddata});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_data_read();
    int m0, r0, l0, f0, v0, d0, q0, bad;
    bit ok;
    fill_tab(8'hA5);
    m0 = mosi_q.size(); r0 = rises; l0 = cs_low_cyc; f0 = cs_falls;
    v0 = vld_cnt; d0 = done_cnt; q0 = rd_q.size();
    run_txn(1'b1, 1'b0, ok);
    repeat (8) @(negedge clk);
    checks++; if (ok !== 1'b1) $display("FAIL read_timeout: got no rddone required rddone"); else passed++;
    checks++; if (mosi_q.size() - m0 !== 20) $display("FAIL read_bytes: got %0d required 20", mosi_q.size() - m0); else passed++;
    checks++; if ({qget(m0), addr_at(m0)} !== 32'h03000000)
      $display("FAIL read_header: got %h required 03000000", {qget(m0), addr_at(m0)}); else passed++;
    bad = 0;
    for (int i = 4; i < 20; i++) if (qget(m0 + i) !== 8'h00) bad++;
    checks++; if (bad !== 0) $display("FAIL read_dummy: got %0d nonzero required 0", bad); else passed++;
    checks++; if (rises - r0 !== 160) $display("FAIL read_sclk_rises: got %0d required 160", rises - r0); else passed++;
    // 20 bytes x 32 clks, 19 one-cycle gaps between bytes, one finish cycle
    checks++; if (cs_low_cyc - l0 !== 660) $display("FAIL read_cs_low: got %0d required 660", cs_low_cyc - l0); else passed++;
    checks++; if (cs_falls - f0 !== 1) $display("FAIL read_cs_frames: got %0d required 1", cs_falls - f0); else passed++;
    checks++; if (vld_cnt - v0 !== 16) $display("FAIL read_vld: got %0d required 16", vld_cnt - v0); else passed++;
    bad = 0;
    for (int i = q0; i < rd_q.size(); i++) if (rd_q[i] !== 8'hA5) bad++;
    checks++; if (bad !== 0) $display("FAIL read_data: got %0d bytes not A5 required 0", bad); else passed++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL read_rddone: got %0d required 1", done_cnt - d0); else passed++;
  endtask

  task automatic test_rdid();
    int m0, v0, d0, q0;
    bit ok;
    fill_tab(8'h00);
    miso_tab[0] = 8'h5A; miso_tab[1] = 8'hEF; miso_tab[2] = 8'h40; miso_tab[3] = 8'h17;
    m0 = mosi_q.size(); v0 = vld_cnt; d0 = done_cnt; q0 = rd_q.size();
    run_txn(1'b0, 1'b1, ok);
    repeat (8) @(negedge clk);
    checks++; if (mosi_q.size() - m0 !== 4) $display("FAIL id_bytes: got %0d required 4", mosi_q.size() - m0); else passed++;
    checks++; if ({qget(m0), addr_at(m0)} !== 32'h9F000000)
      $display("FAIL id_mosi: got %h required 9F000000", {qget(m0), addr_at(m0)}); else passed++;
    checks++; if (vld_cnt - v0 !== 3) $display("FAIL id_vld: got %0d required 3", vld_cnt - v0); else passed++;
    checks++;
    if (rd_q.size() - q0 !== 3 || {rd_q[q0], rd_q[q0 + 1], rd_q[q0 + 2]} !== 24'hEF4017)
      $display("FAIL id_data: got %0d bytes required EF4017", rd_q.size() - q0);
    else passed++;
    checks++; if (ok !== 1'b1 || done_cnt - d0 !== 1) $display("FAIL id_rddone: got %0d required 1", done_cnt - d0); else passed++;
    m0 = mosi_q.size();
    run_txn(1'b1, 1'b0, ok);
    checks++; if (addr_at(m0) !== 24'h000010) $display("FAIL id_keeps_addr: got %h required 000010", addr_at(m0)); else passed++;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ignore();
    int m0, f0, d0, v0;
    bit ok, seen;
    fill_tab(8'h3C);
    m0 = mosi_q.size(); f0 = cs_falls; d0 = done_cnt; v0 = vld_cnt;
    start(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (rddata_vld === 1'b1) seen = 1'b1;
    end
    start(1'b1, 1'b0);
    wait_done(ok);
    repeat (100) @(negedge clk);
    checks++; if (cs_falls - f0 !== 1) $display("FAIL ignore_frames: got %0d required 1", cs_falls - f0); else passed++;
    checks++; if (done_cnt - d0 !== 1) $display("FAIL ignore_rddone: got %0d required 1", done_cnt - d0); else passed++;
    checks++; if (vld_cnt - v0 !== 16) $display("FAIL ignore_vld: got %0d required 16", vld_cnt - v0); else passed++;
    checks++; if (addr_at(m0) !== 24'h000020) $display("FAIL ignore_addr: got %h required 000020", addr_at(m0)); else passed++;
    m0 = mosi_q.size(); f0 = cs_falls; v0 = vld_cnt;
    run_txn(1'b1, 1'b1, ok);
    repeat (100) @(negedge clk);
    checks++; if ({qget(m0), addr_at(m0)} !== 32'h03000030)
      $display("FAIL both_header: got %h required 03000030", {qget(m0), addr_at(m0)}); else passed++;
    checks++; if (mosi_q.size() - m0 !== 20) $display("FAIL both_bytes: got %0d required 20", mosi_q.size() - m0); else passed++;
    checks++; if (cs_falls - f0 !== 1 || vld_cnt - v0 !== 16)
      $display("FAIL both_single: got frames=%0d vld=%0d required 1 and 16", cs_falls - f0, vld_cnt - v0); else passed++;
  endtask

  task automatic test_back_to_back();
    int m0, d0;
    bit ok;
    logic [23:0] exp_addr;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    for (int i = 0; i < 12; i++) begin
      exp_addr = 24'(i * 16);
      m0 = mosi_q.size();
      run_txn(1'b1, 1'b0, ok);
      checks++;
      if (ok !== 1'b1 || addr_at(m0) !== exp_addr)
        $display("FAIL b2b_addr_%0d: got %h required %h", i, addr_at(m0), exp_addr);
      else passed++;
    end
    repeat (8) @(negedge clk);
    checks++; if (done_cnt - d0 !== 12) $display("FAIL b2b_rddone: got %0d required 12", done_cnt - d0); else passed++;
    checks++; if (min_hi < SCLK_DIV) $display("FAIL cs_guard: got %0d cycles high required >= %0d", min_hi, SCLK_DIV); else passed++;
  endtask

  task automatic test_reset_mid();
    int m0, d0;
    bit ok, seen;
    m0 = mosi_q.size();
    start(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (mosi_q.size() - m0 >= 2) seen = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({spi_cs, spi_sclk, spi_mosi, rddata_vld} !== 4'b1000)
      $display("FAIL mid_reset_pins: got cs,sclk,mosi,vld=%b required 1000", {spi_cs, spi_sclk, spi_mosi, rddata_vld}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0) $display("FAIL mid_reset_rddone: got %0d required 0", done_cnt - d0); else passed++;
    m0 = mosi_q.size();
    run_txn(1'b1, 1'b0, ok);
    checks++; if (ok !== 1'b1 || {qget(m0), addr_at(m0)} !== 32'h03000000)
      $display("FAIL mid_reset_restart: got %h required 03000000", {qget(m0), addr_at(m0)}); else passed++;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_data_read();
    test_rdid();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter SCLK_DIV, default 4, clk cycles per SPI clock period (even, >=4).
REQ-002 Parameter RD_LEN, default 16, data bytes returned per read transaction (1..256).
REQ-003 Parameter START_ADDR, default 24'h000000, first flash address read after reset.
REQ-004 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 rden  input  1  one-cycle pulse; starts a data read (cmd 0x03).
REQ-007 rdid  input  1  one-cycle pulse; starts a JEDEC ID read (cmd 0x9F).
REQ-008 rddata  output  8  received byte; valid only while rddata_vld=1.
REQ-009 rddata_vld  output  1  one-cycle strobe per returned byte.
REQ-010 rddone  output  1  one-cycle pulse when a transaction has fully ended.
REQ-011 spi_sclk  output  1  SPI clock, mode 0 (idles low).
REQ-012 spi_mosi  output  1  SPI data out, MSB first.
REQ-013 spi_miso  input  1  SPI data in, sampled on spi_sclk rising edge.
REQ-014 spi_cs  output  1  chip select, active-low.

Function
REQ-015 Block SHALL contain a byte-level SPI engine (req/din/finish in, done/dout out) and a sequencer FSM driving it.
REQ-016 SPI byte: 8 sclk periods of SCLK_DIV clocks; sclk low for first SCLK_DIV/2 clocks, high for the rest.
REQ-017 mosi SHALL be updated while sclk is low, before each rising edge; bit 7 first; held after last bit.
REQ-018 miso SHALL be captured on the clock where sclk rises; shifted in MSB first.
REQ-019 Internal sclk_done SHALL pulse on the last clk of each sclk period; byte done SHALL pulse with the 8th sclk_done, dout valid the same cycle.
REQ-020 spi_cs SHALL go low on the cycle a byte request is accepted from idle and stay low across consecutive bytes with sclk held low between bytes.
REQ-021 finish SHALL raise spi_cs on the next cycle; cs SHALL then stay high at least SCLK_DIV cycles before a new transaction.
REQ-022 Sequencer states: IDLE, CMD, ADDR, DATA, END.
REQ-023 IDLE + rden: CMD sends 0x03, ADDR sends addr[23:16], addr[15:8], addr[7:0], DATA clocks RD_LEN dummy bytes 0x00.
REQ-024 IDLE + rdid: CMD sends 0x9F, ADDR skipped, DATA clocks 3 dummy bytes.
REQ-025 Bytes received during CMD/ADDR SHALL be discarded; each DATA-state byte done SHALL produce rddata=dout and one rddata_vld pulse.
REQ-026 After last DATA byte: END asserts finish; rddone SHALL pulse one cycle after spi_cs returns high; then IDLE.
REQ-027 rden and rdid in the same IDLE cycle: rden wins, rdid dropped.
REQ-028 rden/rdid outside IDLE SHALL be ignored (not queued).
REQ-029 After each completed data read, address SHALL advance by RD_LEN, modulo 2^24 (wrap FFFFFF->000000); ID reads leave it unchanged.
REQ-030 Bytes in a data transaction: exactly 4+RD_LEN; ID transaction: exactly 4.

Reset
REQ-031 During rst: spi_cs=1, spi_sclk=0, spi_mosi=0, rddata=0, rddata_vld=0, rddone=0, FSM=IDLE, address=START_ADDR, counters cleared.
REQ-032 rst mid-transaction SHALL abort on the next edge: cs high, sclk low, no rddone pulse.

Verification
REQ-033 rden pulse after reset, defaults -> mosi shows 0x03,00,00,00; 20 bytes x 32 clks under cs low; 16 rddata_vld pulses; one rddone.
REQ-034 miso driven with 0xA5 per data byte (sampled per sclk_done) -> every rddata = 0xA5.
REQ-035 12 back-to-back rden pulses, each issued after prior rddone -> address bytes 0x000000, 0x000010, ..., 0x0000B0; 12 rddone pulses.
REQ-036 rdid with miso = 0xEF,0x40,0x17 -> mosi 0x9F; three vld strobes with 0xEF,0x40,0x17; rddone.
REQ-037 rden pulsed during DATA; rden+rdid same cycle -> first ignored, no extra transaction; second runs a 0x03 read only.
REQ-038 rst asserted mid-ADDR -> cs=1, sclk=0 next cycle; next rden restarts at START_ADDR.
